branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Lookup side is fetch-facing: a combinational lookup on the fetch PC produces the prediction bit and predicted target.
- Update side consumes the mem-stage branch/jump resolution (update_btb, jump_addr, resolved direction), one update per cycle.
- Closes the predict/resolve loop between IF and MEM.

Parameters:
- INDEX_BITS, 5, log2 of entry count (32 entries); legal range 2..10.
- TAG_BITS, 30-INDEX_BITS, tag width taken from pc[31:INDEX_BITS+2]; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- lookup_pc  input  32  fetch-stage PC.
- predicted_taken  output  1  hit and counter MSB set.
- predicted_target  output  32  stored target on hit, else lookup_pc+4.
- upd_valid  input  1  resolved control-flow instruction in MEM (update_btb).
- upd_pc  input  32  PC of the resolving instruction.
- upd_target  input  32  resolved target (jump_addr).
- upd_taken  input  1  resolved direction (1 for all jumps).

Behaviour:
- Storage per entry:
  - valid (1 bit), tag (TAG_BITS), target (32 bits), ctr (2 bits).
  - index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored.
- Reset (rst=1 at a clk edge):
  - All valid=0, ctr=2'b01, target=0, tag=0, all in one cycle.
  - Outputs are combinational, so during and after reset every lookup misses: predicted_taken=0, predicted_target=lookup_pc+4.
  - upd_valid is ignored while rst=1.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==lookup tag.
  - predicted_taken = hit && ctr[idx][1].
  - predicted_target = predicted_taken ? target[idx] : lookup_pc+4, 32-bit wrap (0xFFFFFFFC -> 0x00000000).
- Update (registered, takes effect at the next clk edge when upd_valid=1):
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate/replace. valid=1, tag=new, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no state change. The tag-mismatched occupant is preserved.
  - upd_valid=0: no state change.
- Saturation: ctr never wraps. 3+taken stays 3; 0+not-taken stays 0.
- Simultaneous lookup and update to the same index, without BTB_BYPASS_EN: lookup sees pre-update contents; the update lands at the edge.
- Aliasing: distinct PCs with equal index and different tag evict each other on taken-allocation only.
- No stall input. Lookup is stateless; IF holds lookup_pc stable during stalls.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined:
  - When upd_valid=1 and upd_pc[31:2]==lookup_pc[31:2] in the same cycle, the lookup outputs reflect the post-update entry state.
  - Example: an entry at ctr=1 with a taken update predicts taken that cycle.
  - Costs one comparator and output muxing on the lookup path.
- Undefined: no forwarding. Same-cycle lookup returns pre-update state.
- Storage and update behaviour are identical either way.

Test Plan:
- Reset then lookup 0x00000100 -> predicted_taken=0, predicted_target=0x00000104. Repeat for lookup 0xFFFFFFFC -> target 0x00000000.
- Update upd_pc=0x00000100, upd_target=0x00000040, taken=1; next cycle lookup 0x00000100 -> taken=1, target=0x00000040 (ctr=2).
- Same PC, four not-taken updates -> ctr 2→1→0→0. Prediction not-taken after the first. One taken update -> ctr=1, still not-taken. Second taken update -> ctr=2, taken.
- Alias with INDEX_BITS=5: allocate 0x00000100 taken, then taken update 0x00000180 (same index, new tag) -> lookup 0x00000100 misses, 0x00000180 hits with the new target. A not-taken update to 0x00000200 leaves 0x00000180 intact.
- Same cycle, entry at ctr=1, taken update + lookup of the same PC -> without macro: predicted_taken=0; with BTB_BYPASS_EN: predicted_taken=1, target=upd_target.
- Assert rst mid-sequence with upd_valid=1 on a populated table -> no entry written. All lookups miss next cycle; a taken update after reset reallocates with ctr=2.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_BYPASS_EN to forward a same-cycle update of the looked-up PC to the lookup outputs.
module branch_target_buffer #(
   parameter  int INDEX_BITS = 5,
   localparam int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        predicted_taken,
   output logic [31:0] predicted_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   logic                r_valid  [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [31:0]         r_target [ENTRIES];
   logic [1:0]          r_ctr    [ENTRIES];

   logic [INDEX_BITS-1:0] w_l_idx, w_u_idx;
   logic [TAG_BITS-1:0]   w_l_tag, w_u_tag;
   logic                  w_u_hit;
   logic                  w_we;
   logic                  w_n_valid;
   logic [TAG_BITS-1:0]   w_n_tag;
   logic [31:0]           w_n_target;
   logic [1:0]            w_n_ctr;
   logic                  w_e_valid;
   logic [TAG_BITS-1:0]   w_e_tag;
   logic [31:0]           w_e_target;
   logic [1:0]            w_e_ctr;
   logic                  w_hit;
   logic                  w_unused;

   assign w_l_idx  = lookup_pc[INDEX_BITS+1:2];
   assign w_l_tag  = lookup_pc[31:INDEX_BITS+2];
   assign w_u_idx  = upd_pc[INDEX_BITS+1:2];
   assign w_u_tag  = upd_pc[31:INDEX_BITS+2];
   assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
   assign w_unused = ^upd_pc[1:0];

   // Post-update image of the entry addressed by upd_pc; w_we marks a real change.
   always_comb begin
      w_we       = 1'b0;
      w_n_valid  = r_valid[w_u_idx];
      w_n_tag    = r_tag[w_u_idx];
      w_n_target = r_target[w_u_idx];
      w_n_ctr    = r_ctr[w_u_idx];
      if (upd_valid) begin
         if (w_u_hit) begin
            w_we = 1'b1;
            if (upd_taken) begin
               w_n_ctr    = (r_ctr[w_u_idx] == 2'd3) ? 2'd3 : r_ctr[w_u_idx] + 2'd1;
               w_n_target = upd_target;
            end else begin
               w_n_ctr    = (r_ctr[w_u_idx] == 2'd0) ? 2'd0 : r_ctr[w_u_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            w_we       = 1'b1;
            w_n_valid  = 1'b1;
            w_n_tag    = w_u_tag;
            w_n_target = upd_target;
            w_n_ctr    = 2'b10;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (w_we) begin
         r_valid[w_u_idx]  <= w_n_valid;
         r_tag[w_u_idx]    <= w_n_tag;
         r_target[w_u_idx] <= w_n_target;
         r_ctr[w_u_idx]    <= w_n_ctr;
      end
   end

   always_comb begin
      w_e_valid  = r_valid[w_l_idx];
      w_e_tag    = r_tag[w_l_idx];
      w_e_target = r_target[w_l_idx];
      w_e_ctr    = r_ctr[w_l_idx];
`ifdef BTB_BYPASS_EN
      if (w_we && (upd_pc[31:2] == lookup_pc[31:2])) begin
         w_e_valid  = w_n_valid;
         w_e_tag    = w_n_tag;
         w_e_target = w_n_target;
         w_e_ctr    = w_n_ctr;
      end
`endif
   end

   // Table contents are about to be cleared, so a reset cycle always misses.
   assign w_hit            = !rst && w_e_valid && (w_e_tag == w_l_tag);
   assign predicted_taken  = w_hit && w_e_ctr[1];
   assign predicted_target = predicted_taken ? w_e_target : lookup_pc + 32'd4;

endmodule
